ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
Programming-side driver for the CCFF configuration chain that feeds mode bits (e.g. the 7-bit MODE_SEL of the scan-FF IO primitive) to logical tiles. It accepts configuration words over a valid/ready interface and serializes them, LSB first, into the chain head. It asserts a shift enable for exactly CHAIN_LEN cycles and captures the bits emerging from the chain tail as a readback word stream, so previous contents can be verified. It sits between the bitstream fetch logic and the chain head/tail of one tile column.

Parameters:
CHAIN_LEN, 7, number of CCFF cells in the chain; the total number of bits shifted per load.
WORD_W, 8, width of write and readback words.
CNT_W, $clog2(CHAIN_LEN+1), width of the shifted-bit counter (derived; do not override).

Ports:
clk_i  in  1  single clock; chain cells capture ccff_head_o on the rising edge when ccff_shift_en_o=1.
rst_i  in  1  synchronous active-high reset.
start_i  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
abort_i  in  1  returns to IDLE from any state on the next edge.
wr_data_i  in  WORD_W  configuration word; bit 0 is shifted first.
wr_valid_i  in  1  wr_data_i valid.
wr_ready_o  out  1  word accepted when wr_valid_i & wr_ready_o.
ccff_head_o  out  1  serial data into chain head (registered).
ccff_shift_en_o  out  1  chain shift enable (registered).
ccff_tail_i  in  1  serial data out of chain tail.
rd_data_o  out  WORD_W  readback word; the first tail bit is in bit 0.
rd_valid_o  out  1  one-cycle pulse; no backpressure.
busy_o  out  1  high in FETCH or SHIFT.
done_o  out  1  high in DONE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; bit counter 0; shift register and readback register cleared.
- States:
  - IDLE: start_i -> FETCH.
  - FETCH: wr_ready_o=1, ccff_shift_en_o=0. Handshake loads the word into the shift register, sets a per-word bit index to 0, then -> SHIFT.
  - SHIFT: each cycle drives ccff_shift_en_o=1 and ccff_head_o=shreg[0], shifts shreg right, increments the bit counter and the per-word index.
    - Bit counter reaches CHAIN_LEN -> DONE.
    - Per-word index reaches WORD_W first -> FETCH.
  - DONE: holds done_o=1 until start_i (-> FETCH with all counters cleared) or abort_i (-> IDLE).
- Starvation: FETCH with wr_valid_i=0 stalls with shift_en=0. The chain holds and no bits are lost or duplicated.
- Final partial word: when CHAIN_LEN is not a multiple of WORD_W, only the low (CHAIN_LEN mod WORD_W) bits of the last word are shifted. The upper bits are discarded.
- Shift timing: ccff_head_o and ccff_shift_en_o change together on the same edge. Exactly CHAIN_LEN cycles have shift_en=1 per load.
- Readback:
  - On every cycle where ccff_shift_en_o=1, ccff_tail_i is sampled into readback bit position (bit count mod WORD_W).
  - rd_valid_o pulses on the cycle after the WORD_W-th bit of a word is captured, and after the final chain bit.
  - A partial final word is zero-padded in its upper bits.
  - rd_data_o holds its value until the next pulse.
- Abort:
  - Forces shift_en=0 immediately on the next edge; enters IDLE.
  - Discards any partial readback word (no rd_valid_o pulse).
  - wr_ready_o drops.
  - A word accepted in the same cycle as abort_i is dropped.
- Simultaneity: abort_i has priority over start_i and over a wr handshake. rst_i has priority over everything.
- Reset mid-load behaves as abort but also clears rd_data_o. The chain contents are left partially shifted; software must reload.
- Underflow/overflow: the counter never exceeds CHAIN_LEN. wr_ready_o is 0 outside FETCH, so extra words are never consumed.

Test Plan:
1. CHAIN_LEN=7, WORD_W=8, chain model preloaded 7'h33; start, write 8'h5A -> ccff_head_o sequence 0,1,0,1,1,0,1 over 7 shift cycles; rd_data_o=8'h33 with one rd_valid_o pulse; done_o=1 after the 7th shift.
2. Immediate second load writing 8'hFF -> readback 8'h5A (bit 7 zero-padded); chain model now holds 7'h7F.
3. CHAIN_LEN=20, WORD_W=8, wr_valid_i withheld 5 cycles between words -> exactly 20 shift_en cycles total, no shift during the stalls; 3 words consumed; 3 rd_valid_o pulses, the last with bits [7:4]=0.
4. abort_i asserted after 3 shifts of test 1 -> shift_en=0 next cycle, IDLE, no rd_valid_o, done_o stays 0; a later start completes normally.
5. rst_i pulsed mid-SHIFT -> all outputs 0 the next cycle; start_i together with abort_i in DONE -> IDLE wins.
6. start_i pulsed while busy_o=1 -> ignored; the shift count stays at CHAIN_LEN.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes configuration words LSB-first into a CCFF
// chain head for exactly CHAIN_LEN shift cycles, and rebuilds the bits that
// emerge from the chain tail into readback words.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 7,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   output logic              ccff_head_o,
   output logic              ccff_shift_en_o,
   input  logic              ccff_tail_i,
   output logic [WORD_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] rd_buf;
   logic [WORD_W-1:0] cap_word;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_nxt;
   logic [IDX_W-1:0]  word_idx;

   // Readback word including the tail bit being captured this cycle.
   always_comb begin
      cap_word           = rd_buf;
      cap_word[word_idx] = ccff_tail_i;
      bit_cnt_nxt        = bit_cnt + CNT_W'(1);
   end

   // Load FSM: head/shift_en are registered so the bit for shift k is
   // presented during the cycle whose closing edge makes the chain shift.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         shreg           <= '0;
         rd_buf          <= '0;
         bit_cnt         <= '0;
         word_idx        <= '0;
         wr_ready_o      <= 1'b0;
         ccff_head_o     <= 1'b0;
         ccff_shift_en_o <= 1'b0;
         rd_data_o       <= '0;
         rd_valid_o      <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
      end else begin
         rd_valid_o <= 1'b0;
         if (abort_i) begin
            // Partial readback and any word handshaken this cycle are dropped.
            state           <= S_IDLE;
            wr_ready_o      <= 1'b0;
            ccff_head_o     <= 1'b0;
            ccff_shift_en_o <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start_i) begin
                     state      <= S_FETCH;
                     bit_cnt    <= '0;
                     word_idx   <= '0;
                     rd_buf     <= '0;
                     wr_ready_o <= 1'b1;
                     busy_o     <= 1'b1;
                     done_o     <= 1'b0;
                  end
               end
               S_FETCH: begin
                  if (wr_valid_i && wr_ready_o) begin
                     state           <= S_SHIFT;
                     ccff_head_o     <= wr_data_i[0];
                     shreg           <= wr_data_i >> 1;
                     ccff_shift_en_o <= 1'b1;
                     wr_ready_o      <= 1'b0;
                     word_idx        <= '0;
                     rd_buf          <= '0;
                  end
               end
               S_SHIFT: begin
                  bit_cnt <= bit_cnt_nxt;
                  rd_buf  <= cap_word;
                  if (bit_cnt_nxt == CNT_W'(CHAIN_LEN)) begin
                     // Upper bits of a final partial word are never shifted.
                     state           <= S_DONE;
                     ccff_head_o     <= 1'b0;
                     ccff_shift_en_o <= 1'b0;
                     rd_data_o       <= cap_word;
                     rd_valid_o      <= 1'b1;
                     busy_o          <= 1'b0;
                     done_o          <= 1'b1;
                  end else if (word_idx == IDX_W'(WORD_W - 1)) begin
                     state           <= S_FETCH;
                     ccff_head_o     <= 1'b0;
                     ccff_shift_en_o <= 1'b0;
                     wr_ready_o      <= 1'b1;
                     rd_data_o       <= cap_word;
                     rd_valid_o      <= 1'b1;
                  end else begin
                     word_idx    <= word_idx + IDX_W'(1);
                     ccff_head_o <= shreg[0];
                     shreg       <= shreg >> 1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (7-cell and 20-cell chains),
// each attached to a behavioural chain model, checked against constant
// tables and a word/bit-stream reference model.
module tb_ccff_chain_loader;

   localparam int LA = 7;
   localparam int LB = 20;
   localparam int W  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         a_start, a_abort, a_wr_valid, a_wr_ready, a_head, a_shift;
   logic         a_tail, a_rd_valid, a_busy, a_done;
   logic [W-1:0] a_wr_data, a_rd_data;
   logic         b_start, b_abort, b_wr_valid, b_wr_ready, b_head, b_shift;
   logic         b_tail, b_rd_valid, b_busy, b_done;
   logic [W-1:0] b_wr_data, b_rd_data;

   ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(a_start), .abort_i(a_abort),
      .wr_data_i(a_wr_data), .wr_valid_i(a_wr_valid), .wr_ready_o(a_wr_ready),
      .ccff_head_o(a_head), .ccff_shift_en_o(a_shift), .ccff_tail_i(a_tail),
      .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .busy_o(a_busy),
      .done_o(a_done));

   ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(b_start), .abort_i(b_abort),
      .wr_data_i(b_wr_data), .wr_valid_i(b_wr_valid), .wr_ready_o(b_wr_ready),
      .ccff_head_o(b_head), .ccff_shift_en_o(b_shift), .ccff_tail_i(b_tail),
      .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .busy_o(b_busy),
      .done_o(b_done));

   // Chain models and monitors
   logic [LA-1:0] a_chain, a_pre_val;
   logic [LB-1:0] b_chain, b_pre_val;
   logic          a_pre_req, b_pre_req;
   logic          a_heads_q[$];
   logic          b_heads_q[$];
   logic [W-1:0]  a_rd_q[$];
   logic [W-1:0]  b_rd_q[$];
   int            a_nshift = 0, a_nacc = 0, b_nshift = 0, b_nacc = 0;

   assign a_tail = a_chain[0];
   assign b_tail = b_chain[0];

   always @(posedge clk) begin
      if (a_pre_req) a_chain <= a_pre_val;
      else if (a_shift) a_chain <= {a_head, a_chain[LA-1:1]};
      if (a_shift) begin a_heads_q.push_back(a_head); a_nshift++; end
      if (a_rd_valid) a_rd_q.push_back(a_rd_data);
      if (a_wr_valid && a_wr_ready) a_nacc++;
   end

   always @(posedge clk) begin
      if (b_pre_req) b_chain <= b_pre_val;
      else if (b_shift) b_chain <= {b_head, b_chain[LB-1:1]};
      if (b_shift) begin b_heads_q.push_back(b_head); b_nshift++; end
      if (b_rd_valid) b_rd_q.push_back(b_rd_data);
      if (b_wr_valid && b_wr_ready) b_nacc++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload_a(input logic [LA-1:0] v);
      a_pre_val = v; a_pre_req = 1'b1; tick(); a_pre_req = 1'b0;
   endtask

   task automatic preload_b(input logic [LB-1:0] v);
      b_pre_val = v; b_pre_req = 1'b1; tick(); b_pre_req = 1'b0;
   endtask

   task automatic wait_a_ready(input string tag);
      int t = 0;
      while (!a_wr_ready && t < 20) begin tick(); t++; end
      check({tag, "_ready"}, a_wr_ready, 1);
   endtask

   task automatic wait_a_done(input string tag);
      int t = 0;
      while (!a_done && t < 60) begin tick(); t++; end
      check({tag, "_done"}, a_done, 1);
   endtask

   task automatic wait_b_ready(input string tag);
      int t = 0;
      while (!b_wr_ready && t < 30) begin tick(); t++; end
      check({tag, "_ready"}, b_wr_ready, 1);
   endtask

   // One full load of the 7-cell chain with given expectations.
   task automatic load_a(input logic [7:0] word, input logic [LA-1:0] exp_heads,
                         input logic [7:0] exp_rd, input bit poke, input string tag);
      int hs, rs, ns;
      logic [LA-1:0] heads;
      hs = a_heads_q.size(); rs = a_rd_q.size(); ns = a_nshift;
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_a_ready(tag);
      a_wr_data = word; a_wr_valid = 1'b1; tick();
      a_wr_valid = 1'b0; a_wr_data = 8'($urandom);
      if (poke) begin
         tick();
         check({tag, "_busy"}, a_busy, 1);
         a_start = 1'b1; tick(); a_start = 1'b0;
      end
      wait_a_done(tag);
      check({tag, "_shifts_at_done"}, a_nshift - ns, LA);
      tick();
      check({tag, "_done_held"}, a_done, 1);
      check({tag, "_shift_total"}, a_nshift - ns, LA);
      heads = 'x;
      if (a_heads_q.size() - hs == LA)
         for (int i = 0; i < LA; i++) heads[i] = a_heads_q[hs + i];
      check({tag, "_heads"}, heads, exp_heads);
      check({tag, "_rd_count"}, a_rd_q.size() - rs, 1);
      if (a_rd_q.size() > rs) check({tag, "_rd_data"}, a_rd_q[rs], exp_rd);
      check({tag, "_chain"}, a_chain, exp_heads);
   endtask

   // Three-word load of the 20-cell chain with stalls, reference model inline.
   task automatic load_b(input logic [23:0] stream, input int stall, input string tag);
      int hs, rs, ns, na, t, bad;
      logic [23:0] oldx;
      logic [LB-1:0] heads;
      oldx = 24'(b_chain);
      hs = b_heads_q.size(); rs = b_rd_q.size(); ns = b_nshift; na = b_nacc;
      bad = 0;
      b_start = 1'b1; tick(); b_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_b_ready(tag);
         if (k > 0)
            for (int s = 0; s < stall; s++) begin
               if (b_shift !== 1'b0) bad++;
               tick();
            end
         b_wr_data = stream[8*k +: 8]; b_wr_valid = 1'b1; tick(); b_wr_valid = 1'b0;
      end
      check({tag, "_stall_no_shift"}, bad, 0);
      t = 0;
      while (!b_done && t < 60) begin tick(); t++; end
      check({tag, "_done"}, b_done, 1);
      check({tag, "_wr_ready_low"}, b_wr_ready, 0);
      b_wr_valid = 1'b1; b_wr_data = 8'($urandom);
      repeat (3) tick();
      b_wr_valid = 1'b0;
      check({tag, "_accepted"}, b_nacc - na, 3);
      check({tag, "_shift_total"}, b_nshift - ns, LB);
      heads = 'x;
      if (b_heads_q.size() - hs == LB)
         for (int i = 0; i < LB; i++) heads[i] = b_heads_q[hs + i];
      check({tag, "_heads"}, heads, stream[LB-1:0]);
      check({tag, "_rd_count"}, b_rd_q.size() - rs, 3);
      for (int k = 0; k < 3; k++)
         if (b_rd_q.size() > rs + k) check({tag, "_rd_word"}, b_rd_q[rs + k], oldx[8*k +: 8]);
      check({tag, "_chain"}, b_chain, stream[LB-1:0]);
   endtask

   typedef struct {
      bit            use_pre;
      logic [LA-1:0] pre;
      logic [7:0]    word;
      logic [LA-1:0] exp_heads;
      logic [7:0]    exp_rd;
      bit            poke;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, rs, na;
      logic [LA-1:0] w7;
      logic [7:0] w8;

      vecs[0] = '{1'b1, 7'h33, 8'h5A, 7'h5A, 8'h33, 1'b0};
      vecs[1] = '{1'b0, 7'h00, 8'hFF, 7'h7F, 8'h5A, 1'b1};
      vecs[2] = '{1'b1, 7'h00, 8'hA5, 7'h25, 8'h00, 1'b0};
      vecs[3] = '{1'b1, 7'h7F, 8'h80, 7'h00, 8'h7F, 1'b0};
      vecs[4] = '{1'b0, 7'h00, 8'h0F, 7'h0F, 8'h00, 1'b0};

      rst = 1'b1;
      a_start = 0; a_abort = 0; a_wr_valid = 0; a_wr_data = '0; a_pre_req = 0; a_pre_val = '0;
      b_start = 0; b_abort = 0; b_wr_valid = 0; b_wr_data = '0; b_pre_req = 0; b_pre_val = '0;
      repeat (3) tick();
      check("reset_a_outputs", {a_wr_ready, a_head, a_shift, a_rd_valid, a_busy, a_done, a_rd_data}, 0);
      check("reset_b_outputs", {b_wr_ready, b_head, b_shift, b_rd_valid, b_busy, b_done, b_rd_data}, 0);
      rst = 1'b0;
      tick();

      // Table-driven loads on the 7-cell chain
      foreach (vecs[i]) begin
         if (vecs[i].use_pre) preload_a(vecs[i].pre);
         load_a(vecs[i].word, vecs[i].exp_heads, vecs[i].exp_rd, vecs[i].poke, $sformatf("vec%0d", i));
      end

      // Abort after 3 shifts
      preload_a(7'h33);
      ns = a_nshift; rs = a_rd_q.size();
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_a_ready("abort");
      a_wr_data = 8'h5A; a_wr_valid = 1'b1; tick(); a_wr_valid = 1'b0;
      begin
         int t = 0;
         while (a_nshift - ns < 3 && t < 20) begin tick(); t++; end
      end
      check("abort_three_shifts", a_nshift - ns, 3);
      a_abort = 1'b1; tick(); a_abort = 1'b0;
      check("abort_state", {a_shift, a_busy, a_done, a_wr_ready}, 0);
      repeat (5) tick();
      check("abort_no_rd", a_rd_q.size() - rs, 0);
      check("abort_done_low", a_done, 0);
      check("abort_shift_stopped", a_nshift - ns, 4);
      w8 = 8'h3C; w7 = w8[LA-1:0];
      load_a(w8, w7, {1'b0, a_chain}, 1'b0, "after_abort");

      // Abort coincident with a write handshake drops the word
      na = a_nacc; ns = a_nshift;
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_a_ready("abort_hs");
      a_wr_data = 8'hC3; a_wr_valid = 1'b1; a_abort = 1'b1; tick();
      a_wr_valid = 1'b0; a_abort = 1'b0;
      check("abort_hs_state", {a_shift, a_busy, a_wr_ready}, 0);
      repeat (3) tick();
      check("abort_hs_no_shift", a_nshift - ns, 0);

      // Reset mid-SHIFT after a load leaving rd_data nonzero
      preload_a(7'h7F);
      load_a(8'h12, 7'h12, 8'h7F, 1'b0, "pre_reset");
      ns = a_nshift;
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_a_ready("rst");
      a_wr_data = 8'h66; a_wr_valid = 1'b1; tick(); a_wr_valid = 1'b0;
      tick();
      check("rst_mid_shift_active", a_shift, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_mid_outputs", {a_wr_ready, a_head, a_shift, a_rd_valid, a_busy, a_done, a_rd_data}, 0);
      tick();

      // Load from the partially shifted chain, then start+abort in DONE
      w8 = 8'h99; w7 = w8[LA-1:0];
      load_a(w8, w7, {1'b0, a_chain}, 1'b0, "post_reset");
      a_start = 1'b1; a_abort = 1'b1; tick(); a_start = 1'b0; a_abort = 1'b0;
      check("start_abort_done", {a_done, a_busy, a_wr_ready, a_shift}, 0);
      tick();
      check("start_abort_idle", {a_done, a_busy, a_wr_ready}, 0);

      // Randomized loads against the chain model
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 1) preload_a(7'($urandom));
         w8 = 8'($urandom); w7 = w8[LA-1:0];
         load_a(w8, w7, {1'b0, a_chain}, 1'($urandom_range(0, 1)), $sformatf("rand_a%0d", i));
      end

      // 20-cell chain: directed stall case then randomized
      preload_b(20'hA5C3F);
      load_b(24'h12_34_56, 5, "b_stall5");
      load_b(24'hFF_00_FF, 0, "b_nostall");
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 1) preload_b(20'($urandom));
         load_b(24'($urandom), int'($urandom_range(0, 6)), $sformatf("rand_b%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
